// File: rtl/cross_bar_pkg.sv
// Shared types and helpers for the crossbar arbitration slice.
// Imported by the weighted round-robin arbiter.
package cross_bar_pkg;

    localparam int MASTER_N = 4;
    localparam int WEIGHT_W = 4;

    typedef enum logic {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/cross_bar_rr_pick.sv
// Combinational rotating-priority picker: the first request at or
// after ptr wins, wrapping to the lowest request otherwise.
module cross_bar_rr_pick #(
    parameter int MASTER_N = 4,
    parameter int IDX_W    = 2
) (
    input  logic [MASTER_N-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [MASTER_N-1:0] pick_onehot,
    output logic [IDX_W-1:0]    pick_idx,
    output logic                pick_valid
);

    logic [MASTER_N-1:0] w_mask;
    logic [MASTER_N-1:0] w_masked;
    logic [MASTER_N-1:0] w_sel;

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < MASTER_N; i++) begin
            w_mask[i] = (IDX_W'(i) >= ptr);
        end
        w_masked = req & w_mask;
        w_sel    = (|w_masked) ? w_masked : req;
    end

    // Scan downward so the lowest set bit wins.
    always_comb begin
        pick_idx = '0;
        for (int i = MASTER_N - 1; i >= 0; i--) begin
            if (w_sel[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    assign pick_valid = |req;

    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < MASTER_N; i++) begin
            pick_onehot[i] = pick_valid && (pick_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/cross_bar_wrr_arbiter.sv
// Weighted round-robin arbiter: an owner keeps the slave port for up
// to weight[i] transactions, then ownership rotates.
module cross_bar_wrr_arbiter
    import cross_bar_pkg::*;
#(
    parameter int   MASTER_N = cross_bar_pkg::MASTER_N,
    parameter int   WEIGHT_W = cross_bar_pkg::WEIGHT_W,
    localparam int  IDX_W    = $clog2(MASTER_N)
) (
    input  logic                         clk,
    input  logic                         aresetn,
    input  logic [MASTER_N-1:0]          req,
    input  logic [MASTER_N-1:0]          last,
    input  logic [MASTER_N*WEIGHT_W-1:0] weight,
    output logic [MASTER_N-1:0]          grant,
    output logic [IDX_W-1:0]             grant_idx,
    output logic                         grant_valid
);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [MASTER_N-1:0]   r_grant;
    logic [MASTER_N-1:0]   w_grant_nxt;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      w_ptr_nxt;
    logic [WEIGHT_W-1:0]   r_credit;
    logic [WEIGHT_W-1:0]   w_credit_nxt;

    logic [MASTER_N-1:0]   w_pick_onehot;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_valid;
    logic [WEIGHT_W-1:0]   w_wt [MASTER_N];
    logic                  w_release;

    for (genvar g = 0; g < MASTER_N; g++) begin : g_wt
        assign w_wt[g] = weight[g*WEIGHT_W +: WEIGHT_W];
    end

    cross_bar_rr_pick #(
        .MASTER_N (MASTER_N),
        .IDX_W    (IDX_W)
    ) u_pick (
        .req         (req),
        .ptr         (r_ptr),
        .pick_onehot (w_pick_onehot),
        .pick_idx    (w_pick_idx),
        .pick_valid  (w_pick_valid)
    );

    // An owner dropping req mid-transaction aborts and still rotates.
    assign w_release = !req[r_idx] ||
                       (last[r_idx] && (r_credit == WEIGHT_W'(1)));

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_idx_nxt    = r_idx;
        w_ptr_nxt    = r_ptr;
        w_credit_nxt = r_credit;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_grant_nxt  = w_pick_onehot;
                    w_idx_nxt    = w_pick_idx;
                    w_credit_nxt = (w_wt[w_pick_idx] == '0) ?
                                   WEIGHT_W'(1) : w_wt[w_pick_idx];
                    w_state_nxt  = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (w_release) begin
                    w_grant_nxt  = '0;
                    w_ptr_nxt    = IDX_W'(rr_next(int'(r_idx), MASTER_N));
                    w_credit_nxt = '0;
                    w_state_nxt  = ARB_IDLE;
                end else if (last[r_idx] && (r_credit > WEIGHT_W'(1))) begin
                    w_credit_nxt = r_credit - WEIGHT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state  <= ARB_IDLE;
            r_grant  <= '0;
            r_idx    <= '0;
            r_ptr    <= '0;
            r_credit <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_idx    <= w_idx_nxt;
            r_ptr    <= w_ptr_nxt;
            r_credit <= w_credit_nxt;
        end
    end

    assign grant       = r_grant;
    assign grant_idx   = r_idx;
    assign grant_valid = |r_grant;

endmodule

// File: tb/tb_cross_bar_wrr_arbiter.sv
// Directed bench for the weighted round-robin crossbar arbiter.
module tb_cross_bar_wrr_arbiter;

    logic        clk;
    logic        aresetn;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] weight;
    logic [3:0]  grant;
    logic [1:0]  grant_idx;
    logic        grant_valid;

    int n_checks;
    int n_fail;

    cross_bar_wrr_arbiter dut (
        .clk         (clk),
        .aresetn     (aresetn),
        .req         (req),
        .last        (last),
        .weight      (weight),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_g(input string tag, input logic [3:0] eg,
                         input logic [1:0] ei);
        chk({tag, ".grant"}, 32'(grant), 32'(eg));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(|eg));
        chk({tag, ".idx"}, 32'(grant_idx), 32'(ei));
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        req     = '0;
        last    = '0;
        step();
        aresetn = 1'b1;
    endtask

    initial begin
        logic [1:0] ix;
        n_checks = 0;
        n_fail   = 0;
        aresetn  = 1'b0;
        req      = '0;
        last     = '0;
        weight   = 16'h1111;
        @(negedge clk);
        chk_g("reset", 4'b0000, 2'd0);
        aresetn = 1'b1;

        // Equal weights: strict rotation with one idle gap.
        req = 4'b1111;
        step();
        for (int k = 0; k < 5; k++) begin
            ix = 2'(k % 4);
            chk_g($sformatf("rot%0d", k), 4'(1 << ix), ix);
            last = 4'(1 << ix);
            step();
            chk_g($sformatf("gap%0d", k), 4'b0000, ix);
            last = '0;
            if (k == 4) req = '0;
            step();
        end
        chk_g("rot_idle", 4'b0000, 2'd0);

        // Weighted quantum: master0 weight 3.
        do_reset();
        weight = 16'h1113;
        req    = 4'b0011;
        step();
        chk_g("wq_g0", 4'b0001, 2'd0);
        last = 4'b0011;
        step();
        chk_g("wq_c2", 4'b0001, 2'd0);
        step();
        chk_g("wq_c1", 4'b0001, 2'd0);
        step();
        chk_g("wq_rel0", 4'b0000, 2'd0);
        step();
        chk_g("wq_g1", 4'b0010, 2'd1);
        step();
        chk_g("wq_rel1", 4'b0000, 2'd1);
        step();
        chk_g("wq_g0b", 4'b0001, 2'd0);
        last = '0;
        req  = '0;
        step();
        chk_g("wq_abort", 4'b0000, 2'd0);

        // Abort: master2 drops req before any last.
        do_reset();
        weight = 16'h1411;
        req    = 4'b0100;
        step();
        chk_g("ab_g2", 4'b0100, 2'd2);
        step();
        chk_g("ab_hold", 4'b0100, 2'd2);
        req = 4'b0000;
        step();
        chk_g("ab_rel", 4'b0000, 2'd2);
        req = 4'b0101;
        step();
        chk_g("ab_wrap", 4'b0001, 2'd0);
        req = 4'b0100;
        step();
        chk_g("ab_rel0", 4'b0000, 2'd0);
        step();
        chk_g("ab_g2b", 4'b0100, 2'd2);

        // Weight 0 treated as 1; foreign last ignored.
        do_reset();
        weight = 16'h1101;
        req    = 4'b0010;
        step();
        chk_g("w0_g1", 4'b0010, 2'd1);
        last = 4'b0001;
        step();
        chk_g("w0_ign", 4'b0010, 2'd1);
        last = 4'b0010;
        step();
        chk_g("w0_rel", 4'b0000, 2'd1);
        last = '0;
        step();
        chk_g("w0_regrant", 4'b0010, 2'd1);

        // Asynchronous reset while master3 owns.
        do_reset();
        weight = 16'h1111;
        req    = 4'b1000;
        step();
        chk_g("ar_g3", 4'b1000, 2'd3);
        aresetn = 1'b0;
        #1;
        chk_g("ar_async", 4'b0000, 2'd0);
        step();
        aresetn = 1'b1;
        step();
        step();
        chk_g("ar_after", 4'b1000, 2'd3);

        // Weight change during ownership applies next grant.
        do_reset();
        weight = 16'h1112;
        req    = 4'b0001;
        step();
        chk_g("wc_g0", 4'b0001, 2'd0);
        weight = 16'h1115;
        last   = 4'b0001;
        step();
        chk_g("wc_c1", 4'b0001, 2'd0);
        step();
        chk_g("wc_rel", 4'b0000, 2'd0);
        last = '0;
        step();
        chk_g("wc_g0b", 4'b0001, 2'd0);
        last = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            step();
            chk_g($sformatf("wc_hold%0d", k), 4'b0001, 2'd0);
        end
        step();
        chk_g("wc_rel5", 4'b0000, 2'd0);
        last = '0;
        req  = '0;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
